// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU execution unit: operation codes,
// FSM state encoding and the LUI immediate shift.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 4'd0;
  localparam alu_op_t ALU_OR  = 4'd1;
  localparam alu_op_t ALU_SLL = 4'd2;
  localparam alu_op_t ALU_SRL = 4'd3;
  localparam alu_op_t ALU_SUB = 4'd4;
  localparam alu_op_t ALU_AND = 4'd5;
  localparam alu_op_t ALU_XOR = 4'd6;
  localparam alu_op_t ALU_LUI = 4'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int LUI_SHIFT = 12;

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shifter: shift register plus down-counter.
// done flags the final step; value_next is the register after this step.
module alu_shift_iter #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   step,
  input  logic                   dir_left,
  input  logic [DATA_WIDTH-1:0]  load_value,
  input  logic [SHAMT_WIDTH-1:0] load_count,
  output logic [DATA_WIDTH-1:0]  value_next,
  output logic                   done
);

  logic [DATA_WIDTH-1:0]  shift_reg;
  logic [SHAMT_WIDTH-1:0] count_reg;
  logic                   left_reg;

  assign value_next = left_reg ? (shift_reg << 1) : (shift_reg >> 1);
  assign done       = (count_reg == SHAMT_WIDTH'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      count_reg <= '0;
      left_reg  <= 1'b0;
    end else if (load) begin
      shift_reg <= load_value;
      count_reg <= load_count;
      left_reg  <= dir_left;
    end else if (step) begin
      shift_reg <= value_next;
      count_reg <= count_reg - SHAMT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/alu_seq_exec.sv
// Sequential ALU execution unit with valid/ready on both sides.
// Define ALU_BARREL_SHIFT_EN for single-cycle shifts via a barrel shifter.
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [3:0]            alu_op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic                  illegal_o
);

  logic [1:0]             state;
  logic [DATA_WIDTH-1:0]  result_reg;
  logic                   zero_reg;
  logic                   illegal_reg;
  logic [DATA_WIDTH-1:0]  op_result;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   is_shift;
  logic                   capture;
  logic                   go_shift;
  logic                   shift_last;
  logic [DATA_WIDTH-1:0]  shift_next;

  assign shamt       = b_i[SHAMT_WIDTH-1:0];
  assign is_shift    = (alu_op_i == ALU_SLL) || (alu_op_i == ALU_SRL);
  assign in_ready_o  = (state == ST_IDLE);
  assign out_valid_o = (state == ST_DONE);
  assign capture     = in_valid_i && in_ready_o;
  assign result_o    = result_reg;
  assign zero_o      = zero_reg;
  assign illegal_o   = illegal_reg;

  always_comb begin
    op_result = '0;
    case (alu_op_i)
      ALU_ADD: op_result = a_i + b_i;
      ALU_OR:  op_result = a_i | b_i;
      ALU_SUB: op_result = a_i - b_i;
      ALU_AND: op_result = a_i & b_i;
      ALU_XOR: op_result = a_i ^ b_i;
      ALU_LUI: op_result = b_i << LUI_SHIFT;
`ifdef ALU_BARREL_SHIFT_EN
      ALU_SLL: op_result = a_i << shamt;
      ALU_SRL: op_result = a_i >> shamt;
`else
      // Only reached with shamt == 0; nonzero amounts go through the iterator.
      ALU_SLL: op_result = a_i;
      ALU_SRL: op_result = a_i;
`endif
      default: op_result = '0;
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN
  assign go_shift   = 1'b0;
  assign shift_last = 1'b0;
  assign shift_next = '0;
`else
  assign go_shift = is_shift && (shamt != '0);

  alu_shift_iter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_WIDTH(SHAMT_WIDTH)
  ) u_shift_iter (
    .clk       (clk),
    .reset     (reset),
    .load      (capture && go_shift),
    .step      (state == ST_SHIFT),
    .dir_left  (alu_op_i == ALU_SLL),
    .load_value(a_i),
    .load_count(shamt),
    .value_next(shift_next),
    .done      (shift_last)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      result_reg  <= '0;
      zero_reg    <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (capture) begin
            if (go_shift) begin
              state <= ST_SHIFT;
            end else begin
              state       <= ST_DONE;
              result_reg  <= op_result;
              zero_reg    <= (op_result == '0);
              illegal_reg <= alu_op_i[3];
            end
          end
        end
        ST_SHIFT: begin
          // The last single-bit step lands directly in the result register.
          if (shift_last) begin
            state       <= ST_DONE;
            result_reg  <= shift_next;
            zero_reg    <= (shift_next == '0);
            illegal_reg <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec using a scoreboard of expected results.
// Latency expectations follow ALU_BARREL_SHIFT_EN when it is defined.
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [3:0]  alu_op_i = '0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] result_o;
  logic        zero_o;
  logic        illegal_o;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    int          lat;
    logic [3:0]  op;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   cap_cyc = 0;

  alu_seq_exec #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .alu_op_i   (alu_op_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .result_o   (result_o),
    .zero_o     (zero_o),
    .illegal_o  (illegal_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a | b;
      4'd2: return a << b[4:0];
      4'd3: return a >> b[4:0];
      4'd4: return a - b;
      4'd5: return a & b;
      4'd6: return a ^ b;
      4'd7: return {b[19:0], 12'h000};
      default: return 32'h0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    if ((op == 4'd2 || op == 4'd3) && b[4:0] != 5'd0) return 1 + int'(b[4:0]);
    return 1;
`endif
  endfunction

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    compared++;
    if (in_ready_o !== 1'b1) begin
      mismatched++;
      $display("FAIL send_ready: in_ready_o=%b required 1", in_ready_o);
    end
    e.result  = model(op, a, b);
    e.zero    = (e.result == 32'h0);
    e.illegal = op[3];
    e.lat     = exp_lat(op, b);
    e.op      = op;
    sb.push_back(e);
    alu_op_i = op; a_i = a; b_i = b; in_valid_i = 1'b1;
    @(posedge clk); #1;
    cap_cyc = cyc;
    in_valid_i = 1'b0;
    alu_op_i = 4'($urandom); a_i = $urandom; b_i = $urandom;
  endtask

  task automatic collect(input bit retire);
    exp_t e;
    int   n = 0;
    int   lat;
    while (out_valid_o !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      compared++; mismatched++;
      $display("FAIL timeout: out_valid_o never rose within 200 cycles");
      return;
    end
    lat = cyc - cap_cyc + 1;
    e = sb.pop_front();
    $display("txn op=%0d result=%08h zero=%b illegal=%b lat=%0d (exp %08h lat %0d)",
             e.op, result_o, zero_o, illegal_o, lat, e.result, e.lat);
    compared += 5;
    if (lat != e.lat) begin
      mismatched++; $display("FAIL latency: got %0d required %0d", lat, e.lat);
    end
    if (result_o !== e.result) begin
      mismatched++; $display("FAIL result: got %08h required %08h", result_o, e.result);
    end
    if (zero_o !== e.zero) begin
      mismatched++; $display("FAIL zero: got %b required %b", zero_o, e.zero);
    end
    if (illegal_o !== e.illegal) begin
      mismatched++; $display("FAIL illegal: got %b required %b", illegal_o, e.illegal);
    end
    if (in_ready_o !== 1'b0) begin
      mismatched++; $display("FAIL done_ready: in_ready_o=%b required 0", in_ready_o);
    end
    if (retire) begin
      @(negedge clk); out_ready_i = 1'b1;
      @(posedge clk); #1; out_ready_i = 1'b0;
      compared += 2;
      if (out_valid_o !== 1'b0) begin
        mismatched++; $display("FAIL retire_valid: out_valid_o=%b required 0", out_valid_o);
      end
      if (in_ready_o !== 1'b1) begin
        mismatched++; $display("FAIL retire_ready: in_ready_o=%b required 1", in_ready_o);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    compared += 5;
    if (out_valid_o !== 1'b0) begin mismatched++; $display("FAIL %s out_valid: %b required 0", tag, out_valid_o); end
    if (in_ready_o !== 1'b1) begin mismatched++; $display("FAIL %s in_ready: %b required 1", tag, in_ready_o); end
    if (result_o !== 32'h0) begin mismatched++; $display("FAIL %s result: %08h required 0", tag, result_o); end
    if (zero_o !== 1'b0) begin mismatched++; $display("FAIL %s zero: %b required 0", tag, zero_o); end
    if (illegal_o !== 1'b0) begin mismatched++; $display("FAIL %s illegal: %b required 0", tag, illegal_o); end
  endtask

  task automatic test_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_arith();
    send(4'd0, 32'd5, 32'd7);  collect(1'b1);
    send(4'd4, 32'd7, 32'd7);  collect(1'b1);
    send(4'd1, 32'hF0F0_0000, 32'h0000_0F0F); collect(1'b1);
    send(4'd5, 32'hFFFF_00FF, 32'h0F0F_0F0F); collect(1'b1);
    send(4'd0, 32'hFFFF_FFFF, 32'd1); collect(1'b1);
  endtask

  task automatic test_shift();
    send(4'd2, 32'd1, 32'd31);          collect(1'b1);
    send(4'd3, 32'h8000_0000, 32'd4);   collect(1'b1);
    send(4'd2, 32'hDEAD_BEEF, 32'd0);   collect(1'b1);
    send(4'd3, 32'hA5A5_A5A5, 32'h0000_0021); collect(1'b1);
  endtask

  task automatic test_lui_illegal();
    send(4'd7, 32'hFFFF_FFFF, 32'h0001_2345); collect(1'b1);
    send(4'd9, 32'd3, 32'd4);  collect(1'b1);
    send(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF); collect(1'b1);
  endtask

  task automatic test_backpressure();
    send(4'd6, 32'h1234_5678, 32'h0F0F_0F0F);
    collect(1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid_i = 1'b1; alu_op_i = 4'd0; a_i = $urandom; b_i = $urandom;
      @(posedge clk); #1;
      compared += 3;
      if (result_o !== (32'h1234_5678 ^ 32'h0F0F_0F0F)) begin
        mismatched++; $display("FAIL bp_result: got %08h required %08h", result_o, 32'h1234_5678 ^ 32'h0F0F_0F0F);
      end
      if (in_ready_o !== 1'b0) begin mismatched++; $display("FAIL bp_ready: %b required 0", in_ready_o); end
      if (out_valid_o !== 1'b1) begin mismatched++; $display("FAIL bp_valid: %b required 1", out_valid_o); end
    end
    @(negedge clk); in_valid_i = 1'b0; out_ready_i = 1'b1;
    @(posedge clk); #1; out_ready_i = 1'b0;
    compared += 2;
    if (in_ready_o !== 1'b1) begin mismatched++; $display("FAIL bp_release_ready: %b required 1", in_ready_o); end
    if (out_valid_o !== 1'b0) begin mismatched++; $display("FAIL bp_release_valid: %b required 0", out_valid_o); end
    $display("txn backpressure held 10 cycles and released");
  endtask

  task automatic test_reset_mid_shift();
    @(negedge clk);
    alu_op_i = 4'd2; a_i = 32'd1; b_i = 32'd20; in_valid_i = 1'b1;
    @(posedge clk); #1; in_valid_i = 1'b0;
    repeat (8) @(posedge clk);
    #3 reset = 1'b1;
    #1 check_reset_outputs("mid_shift_reset");
    $display("txn reset asserted during shift");
    @(negedge clk); reset = 1'b0;
    send(4'd6, 32'h0000_00FF, 32'h0000_000F); collect(1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 4'($urandom_range(0, 9));
      a  = $urandom;
      b  = $urandom;
      if (op == 4'd2 || op == 4'd3) b = 32'($urandom_range(0, 12));
      send(op, a, b);
      collect(1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_lui_illegal();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
